// File: rtl/softmax_seq_ctrl_pkg.sv
// Shared definitions for the softmax exp sequencer: controller state encoding
// plus the datapath format constants the stage selects must agree with.
package softmax_seq_ctrl_pkg;

    localparam int OUTPUT_BUF_DATASIZE = 16;
    localparam int FIXPOINT_FRAC       = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_CLR  = 3'd1,
        ST_SUM  = 3'd2,
        ST_LN   = 3'd3,
        ST_NORM = 3'd4,
        ST_DONE = 3'd5
    } state_t;

endpackage

// File: rtl/valid_pipe.sv
// Valid-bit shift register that tracks items in flight through a fixed-latency
// datapath; freezes with the datapath when en is low.
module valid_pipe #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    input  logic push,
    output logic valid,
    output logic pending
);

    // Every stage except the output one; used to detect "empty after this cycle".
    localparam logic [DEPTH-1:0] LOW_MASK = {DEPTH{1'b1}} >> 1;

    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sr <= '0;
        end else if (en) begin
            sr <= (sr << 1) | DEPTH'(push);
        end
    end

    assign valid   = sr[DEPTH-1];
    assign pending = |(sr & LOW_MASK);

endmodule

// File: rtl/softmax_seq_ctrl.sv
// Row sequencer for the softmax exp datapath: clear, sum exp(Xi), ln(F),
// then write exp(Xi - lnF) back in place. Control only, no data.
module softmax_seq_ctrl
    import softmax_seq_ctrl_pkg::*;
#(
    parameter int ROW_LEN = 16,
    parameter int ADDR_W  = 8,
    parameter int EXP_LAT = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              hold,
    input  logic              ln_done,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              is_stage2,
    output logic              is_stage4,
    output logic              pipe_en,
    output logic              acc_clr,
    output logic              acc_en,
    output logic              ln_start,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam int CNT_W      = $clog2(ROW_LEN + 1);
    localparam int PIPE_DEPTH = 1 + EXP_LAT;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  rd_cnt, wr_cnt;
    logic              ln_sent;
    logic              vld, pending, reads_done, streaming;

    assign reads_done = (rd_cnt == CNT_W'(ROW_LEN));
    assign streaming  = (state == ST_SUM) || (state == ST_NORM);
    assign pipe_en    = ~hold;
    assign rd_addr    = base_q + ADDR_W'(rd_cnt);
    assign wr_addr    = base_q + ADDR_W'(wr_cnt);

    valid_pipe #(.DEPTH(PIPE_DEPTH)) u_valid_pipe (
        .clk    (clk),
        .clr    (rst),
        .en     (~hold),
        .push   (rd_en),
        .valid  (vld),
        .pending(pending)
    );

    always_comb begin
        state_nxt = state;
        busy      = 1'b1;
        done      = 1'b0;
        rd_en     = 1'b0;
        is_stage2 = 1'b0;
        is_stage4 = 1'b0;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;
        ln_start  = 1'b0;
        wr_en     = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = ST_CLR;
            end
            ST_CLR: begin
                acc_clr   = 1'b1;
                state_nxt = ST_SUM;
            end
            ST_SUM: begin
                is_stage2 = 1'b1;
                rd_en     = ~reads_done;
                acc_en    = vld;
                // Leave once the last item is leaving the pipe this cycle.
                if (reads_done && !pending) state_nxt = ST_LN;
            end
            ST_LN: begin
                ln_start = ~ln_sent;
                if (ln_done) state_nxt = ST_NORM;
            end
            ST_NORM: begin
                is_stage4 = 1'b1;
                rd_en     = ~reads_done;
                wr_en     = vld;
                if (reads_done && !pending) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // A stall suppresses every strobe and pulse; they fire once released.
        if (hold) begin
            state_nxt = state;
            rd_en     = 1'b0;
            acc_en    = 1'b0;
            wr_en     = 1'b0;
            ln_start  = 1'b0;
            acc_clr   = 1'b0;
            done      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            base_q  <= '0;
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            ln_sent <= 1'b0;
        end else if (!hold) begin
            state   <= state_nxt;
            ln_sent <= (state == ST_LN);
            if (state == ST_IDLE && start) base_q <= base_addr;
            if (!streaming)  rd_cnt <= '0;
            else if (rd_en)  rd_cnt <= rd_cnt + CNT_W'(1);
            if (state != ST_NORM) wr_cnt <= '0;
            else if (wr_en)       wr_cnt <= wr_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_softmax_seq_ctrl.sv
// Randomised bench for softmax_seq_ctrl: two instances (ROW_LEN 4 and 1) checked
// each cycle against a timeline model counted in non-stalled cycles.
module tb_softmax_seq_ctrl;

    localparam int EXP_LAT = 3;
    localparam int R0      = 4;
    localparam int R1      = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       hold = 1'b0;
    logic [7:0] base_addr = 8'h00;
    logic [1:0] ln_done = 2'b00;
    logic [1:0] busy, done, rd_en, is2, is4, pipe_en, acc_clr, acc_en, ln_start, wr_en;
    logic [7:0] rd_addr [2];
    logic [7:0] wr_addr [2];

    always #5 clk = ~clk;

    softmax_seq_ctrl #(.ROW_LEN(R0), .ADDR_W(8), .EXP_LAT(EXP_LAT)) dut0 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .hold(hold),
        .ln_done(ln_done[0]), .busy(busy[0]), .done(done[0]), .rd_en(rd_en[0]),
        .rd_addr(rd_addr[0]), .is_stage2(is2[0]), .is_stage4(is4[0]), .pipe_en(pipe_en[0]),
        .acc_clr(acc_clr[0]), .acc_en(acc_en[0]), .ln_start(ln_start[0]), .wr_en(wr_en[0]),
        .wr_addr(wr_addr[0])
    );

    softmax_seq_ctrl #(.ROW_LEN(R1), .ADDR_W(8), .EXP_LAT(EXP_LAT)) dut1 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .hold(hold),
        .ln_done(ln_done[1]), .busy(busy[1]), .done(done[1]), .rd_en(rd_en[1]),
        .rd_addr(rd_addr[1]), .is_stage2(is2[1]), .is_stage4(is4[1]), .pipe_en(pipe_en[1]),
        .acc_clr(acc_clr[1]), .acc_en(acc_en[1]), .ln_start(ln_start[1]), .wr_en(wr_en[1]),
        .wr_addr(wr_addr[1])
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model: a = index of the next non-stalled cycle of the row (0 = idle),
    // n0 = active index where NORM starts (0 until ln_done is seen in LN).
    int         a [2]         = '{0, 0};
    int         n0 [2]        = '{0, 0};
    logic [7:0] b [2]         = '{8'h00, 8'h00};
    int         start_cyc [2] = '{-1, -1};
    int         done_cyc [2]  = '{-1, -1};
    int         ln_cnt [2]    = '{0, 0};
    int         ln_lat        = 3;
    logic [1:0] prev_ls       = 2'b00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    function automatic logic [9:0] pack_out(input int i);
        return {busy[i], done[i], rd_en[i], is2[i], is4[i], acc_clr[i], acc_en[i],
                ln_start[i], wr_en[i], pipe_en[i]};
    endfunction

    task automatic model_check(input int i, input int R);
        int         x, aln;
        logic [9:0] want;
        logic       sum_rd, in_norm, norm_rd, e_rd, e_wr;
        logic [7:0] e_ra, e_wa;
        x = a[i];
        aln = R + 3 + EXP_LAT;
        e_rd = 1'b0; e_wr = 1'b0; e_ra = 8'h00; e_wa = 8'h00;
        want = {9'b0, ~hold};
        if (x != 0) begin
            sum_rd  = (x >= 2) && (x <= R + 1);
            in_norm = (n0[i] != 0) && (x >= n0[i]) && (x <= n0[i] + R + EXP_LAT);
            norm_rd = in_norm && (x < n0[i] + R);
            e_rd    = (sum_rd || norm_rd) && !hold;
            e_ra    = sum_rd ? b[i] + 8'(x - 2) : b[i] + 8'(x - n0[i]);
            e_wr    = in_norm && (x >= n0[i] + 1 + EXP_LAT) && !hold;
            e_wa    = b[i] + 8'(x - n0[i] - 1 - EXP_LAT);
            want = {1'b1,
                    (n0[i] != 0) && (x == n0[i] + R + EXP_LAT + 1) && !hold,
                    e_rd,
                    (x >= 2) && (x <= R + 2 + EXP_LAT),
                    in_norm,
                    (x == 1) && !hold,
                    (x >= 3 + EXP_LAT) && (x <= R + 2 + EXP_LAT) && !hold,
                    (x == aln) && !hold,
                    e_wr,
                    ~hold};
        end
        check($sformatf("ctl%0d_c%0d", i, cyc), 32'(pack_out(i)), 32'(want));
        if (e_rd) check($sformatf("rd_addr%0d_c%0d", i, cyc), 32'(rd_addr[i]), 32'(e_ra));
        if (e_wr) check($sformatf("wr_addr%0d_c%0d", i, cyc), 32'(wr_addr[i]), 32'(e_wa));
        if (done[i]) done_cyc[i] = cyc;
        if (x == 0) begin
            if (start && !hold && !rst) begin
                a[i] = 1; b[i] = base_addr; n0[i] = 0; start_cyc[i] = cyc;
            end
        end else if (!hold) begin
            if (n0[i] == 0 && x >= aln && ln_done[i]) n0[i] = x + 1;
            if (n0[i] != 0 && x == n0[i] + R + EXP_LAT + 1) a[i] = 0;
            else a[i] = x + 1;
        end
    endtask

    // Drive one cycle's inputs at the falling edge, act as the ln unit, then check.
    task automatic step(input logic st, input logic h, input logic [7:0] ba);
        @(negedge clk);
        start = st; hold = h; base_addr = ba;
        for (int i = 0; i < 2; i++) begin
            if (prev_ls[i]) begin
                ln_cnt[i]  = ln_lat - 1;
                ln_done[i] = (ln_cnt[i] == 0);
            end else if (ln_cnt[i] > 0) begin
                ln_cnt[i]--;
                if (ln_cnt[i] == 0) ln_done[i] = 1'b1;
            end
        end
        #1;
        model_check(0, R0);
        model_check(1, R1);
        prev_ls = ln_start;
        cyc++;
    endtask

    task automatic row_latency(input string tag, input int d0, input int d1);
        check({tag, "_d0"}, 32'(done_cyc[0] - start_cyc[0]), 32'(d0));
        check({tag, "_d1"}, 32'(done_cyc[1] - start_cyc[1]), 32'(d1));
        done_cyc = '{-1, -1};
    endtask

    initial begin
        int k;
        step(0, 0, 8'h00);
        step(0, 0, 8'h00);
        check("rst_rd_addr", 32'(rd_addr[0]), 32'h0);
        check("rst_wr_addr", 32'(wr_addr[0]), 32'h0);
        rst = 1'b0;

        // Reference row: base 0x10, ln_done three cycles after ln_start.
        step(1, 0, 8'h10);
        repeat (40) step(0, 0, 8'h55);
        row_latency("lat_row1", 22, 16);

        // Wrap across the top of the address space; ln_done is still high.
        step(1, 0, 8'hFE);
        repeat (40) step(0, 0, 8'h00);
        row_latency("lat_wrap", 19, 13);

        // Three-cycle stall after the second read, plus a start while busy.
        step(1, 0, 8'h20);
        repeat (3) step(0, 0, 8'h00);
        repeat (3) step(0, 1, 8'h00);
        step(0, 0, 8'h00);
        step(1, 0, 8'h80);
        repeat (40) step(0, 0, 8'h00);
        row_latency("lat_hold", 22, 16);

        repeat (1500) begin
            for (int i = 0; i < 2; i++)
                if (a[i] == 0 && $urandom_range(2) == 0) ln_done[i] = 1'b0;
            ln_lat = 1 + $urandom_range(3);
            step($urandom_range(3) == 0, $urandom_range(4) == 0,
                 ($urandom_range(3) == 0) ? (8'hFC | 8'($urandom_range(3))) : 8'($urandom));
        end
        repeat (80) step(0, 0, 8'h00);

        // Asynchronous reset in the middle of NORM.
        step(1, 0, 8'h40);
        k = 0;
        while (!(n0[0] != 0 && a[0] >= n0[0] + 2) && k < 100) begin
            step(0, 0, 8'h00);
            k++;
        end
        check("norm_reached", 32'(k < 100), 32'h1);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst_ctl%0d", i), 32'(pack_out(i)), 32'h1);
            check($sformatf("rst_rda%0d", i), 32'(rd_addr[i]), 32'h0);
            check($sformatf("rst_wra%0d", i), 32'(wr_addr[i]), 32'h0);
        end
        a = '{0, 0};
        n0 = '{0, 0};
        @(negedge clk);
        rst = 1'b0;
        repeat (20) step(0, 0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
